// File: rtl/x9_loader_pkg.sv
// x9_loader_pkg: loader FSM states and data-memory widths shared with top_level's dm1.
package x9_loader_pkg;
  localparam int LOADER_AW = 8;
  localparam int LOADER_DW = 8;
  localparam int LOADER_CW = 16;
  typedef enum logic [2:0] {SEG_BASE, SEG_CNT, SEG_DATA, LAUNCH, RUN, DONE} loader_state_e;
endpackage

// File: rtl/dm_boot_loader_if.sv
// dm_boot_loader_if: valid/ready byte stream feeding the boot loader.
interface dm_boot_loader_if #(parameter int DW = x9_loader_pkg::LOADER_DW);
  logic in_valid;
  logic in_ready;
  logic in_last;
  logic [DW-1:0] in_data;
  modport master(output in_valid, in_data, in_last, input in_ready);
  modport slave(input in_valid, in_data, in_last, output in_ready);
endinterface

// File: rtl/sat_counter.sv
// sat_counter: up-counter with synchronous clear that holds at all-ones.
module sat_counter #(parameter int CW = 16) (
  input  logic          clk,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] q,
  output logic          at_max
);
  assign at_max = &q;
  always_ff @(posedge clk) q <= clr ? '0 : (en && !at_max) ? q + 1'b1 : q;
endmodule

// File: rtl/dm_boot_loader.sv
// dm_boot_loader: streams BASE/N/data segments into data memory, then runs the CPU and counts cycles.
// Optional RUN-cycle limit enabled by LOADER_TIMEOUT_EN.
module dm_boot_loader import x9_loader_pkg::*; #(
  parameter int AW = LOADER_AW,
  parameter int DW = LOADER_DW,
  parameter int CW = LOADER_CW,
  parameter int TIMEOUT = 4096
) (
  input  logic           clk,
  input  logic           reset,
  dm_boot_loader_if.slave s,
  output logic           dm_wr_en,
  output logic [AW-1:0]  dm_addr,
  output logic [DW-1:0]  dm_wr_data,
  output logic           cpu_reset,
  input  logic           cpu_done,
  output logic           busy,
  output logic           finished,
  output logic           timed_out,
  output logic [CW-1:0]  cycles
);
`ifdef LOADER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  loader_state_e state, state_n;
  logic [AW-1:0] ptr;
  logic [DW-1:0] rem;
  logic wr_q, fire, to_hit, sat;
  assign s.in_ready = !reset && state inside {SEG_BASE, SEG_CNT, SEG_DATA};
  assign fire = s.in_valid && s.in_ready;
  assign to_hit = TO_EN && state == RUN && !cpu_done && cycles == CW'(TIMEOUT - 1);
  // a write still in flight when reset lands must not reach memory
  assign dm_wr_en = wr_q && !reset;
  assign cpu_reset = !(state == RUN || (state == DONE && !timed_out));
  assign busy = state != DONE;
  assign finished = state == DONE;
  always_comb begin
    state_n = state;
    case (state)
      SEG_BASE: if (fire) state_n = SEG_CNT;
      SEG_CNT:  if (fire) state_n = s.in_data != '0 ? SEG_DATA : s.in_last ? LAUNCH : SEG_BASE;
      SEG_DATA: if (fire && rem == DW'(1)) state_n = s.in_last ? LAUNCH : SEG_BASE;
      LAUNCH:   state_n = RUN;
      RUN:      if (cpu_done || to_hit) state_n = DONE;
      default:  state_n = DONE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SEG_BASE;
      ptr <= '0;
      rem <= '0;
      wr_q <= 1'b0;
      dm_addr <= '0;
      dm_wr_data <= '0;
      timed_out <= 1'b0;
    end else begin
      state <= state_n;
      wr_q <= fire && state == SEG_DATA;
      if (fire && state == SEG_BASE) ptr <= AW'(s.in_data);
      if (fire && state == SEG_CNT) rem <= s.in_data;
      if (fire && state == SEG_DATA) begin
        ptr <= ptr + 1'b1;
        rem <= rem - 1'b1;
        dm_addr <= ptr;
        dm_wr_data <= s.in_data;
      end
      if (to_hit) timed_out <= 1'b1;
    end
  end
  sat_counter #(.CW(CW)) u_cycles (
    .clk(clk),
    .clr(reset),
    .en(state == RUN && state_n == RUN && !sat),
    .q(cycles),
    .at_max(sat)
  );
endmodule

// File: tb/tb_dm_boot_loader.sv
// tb_dm_boot_loader: random segment streams checked against a segment-level write/memory model.
module tb_dm_boot_loader;
  localparam int T = 8;
  logic clk = 1'b0, reset = 1'b1, cpu_done = 1'b0;
  logic dm_wr_en, cpu_reset, busy, finished, timed_out;
  logic [7:0] dm_addr, dm_wr_data;
  logic [15:0] cycles;
  int checks = 0, errors = 0;
  logic [8:0] stream[$];
  logic [15:0] exp_wr[$], obs_wr[$];
  logic [7:0] dq[$];
  logic [7:0] em[256];
  bit touched[256];
  dm_boot_loader_if #(.DW(8)) bus();
  dm_boot_loader #(.AW(8), .DW(8), .CW(16), .TIMEOUT(T)) dut (
    .clk(clk), .reset(reset), .s(bus),
    .dm_wr_en(dm_wr_en), .dm_addr(dm_addr), .dm_wr_data(dm_wr_data),
    .cpu_reset(cpu_reset), .cpu_done(cpu_done), .busy(busy), .finished(finished),
    .timed_out(timed_out), .cycles(cycles)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (dm_wr_en) obs_wr.push_back({dm_addr, dm_wr_data});
  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic new_test();
    stream.delete();
    exp_wr.delete();
    dq.delete();
    for (int a = 0; a < 256; a++) touched[a] = 1'b0;
  endtask
  task automatic do_reset();
    obs_wr.delete();
    bus.in_valid = 1'b0;
    cpu_done = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("rst_ready", bus.in_ready, 0);
    chk("rst_wr_drop", dm_wr_en, 0);
    @(posedge clk); #1;
    chk("rst_vals", {dm_wr_en, dm_addr, dm_wr_data, cpu_reset, busy, finished, timed_out, cycles},
        {1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000});
    reset = 1'b0;
    #1 chk("post_rst_ready", bus.in_ready, 1);
  endtask
  task automatic add_seg(input logic [7:0] base, input bit fin);
    int n = dq.size();
    stream.push_back({1'($urandom), base});
    stream.push_back({(n == 0) ? fin : 1'($urandom), 8'(n)});
    for (int i = 0; i < n; i++) begin
      stream.push_back({(i == n - 1) ? fin : 1'($urandom), dq[i]});
      exp_wr.push_back({base + 8'(i), dq[i]});
      em[base + 8'(i)] = dq[i];
      touched[base + 8'(i)] = 1'b1;
    end
    dq.delete();
  endtask
  task automatic send(input logic [8:0] b, input int gap);
    int n = 0;
    repeat (gap) begin
      @(negedge clk);
      bus.in_data = 8'($urandom);
      bus.in_last = 1'($urandom);
    end
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data = b[7:0];
    bus.in_last = b[8];
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("ready_wait", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask
  task automatic send_all();
    foreach (stream[i]) send(stream[i], $urandom_range(0, 3));
    chk("launch_cpu_reset", cpu_reset, 1);
    chk("launch_ready", bus.in_ready, 0);
    @(posedge clk); #1;
    chk("run_cpu_reset", cpu_reset, 0);
    chk("run_cycles0", cycles, 0);
  endtask
  task automatic run_stream(input int k);
    bit to;
    logic [15:0] ec;
    logic [7:0] om[256];
    int m;
`ifdef LOADER_TIMEOUT_EN
    to = k > T - 1;
`else
    to = 1'b0;
`endif
    ec = to ? 16'(T - 1) : 16'(k);
    send_all();
    repeat (k) @(posedge clk);
    #1 cpu_done = 1'b1;
    @(posedge clk); #1;
    cpu_done = 1'b0;
    chk("done_flags", {finished, busy, timed_out, cpu_reset}, {1'b1, 1'b0, to, to});
    chk("done_cycles", cycles, ec);
    repeat (3) @(posedge clk);
    #1 chk("done_hold", {finished, cycles}, {1'b1, ec});
    chk("wr_count", obs_wr.size(), exp_wr.size());
    m = obs_wr.size() < exp_wr.size() ? obs_wr.size() : exp_wr.size();
    for (int i = 0; i < m; i++) chk($sformatf("wr%0d", i), obs_wr[i], exp_wr[i]);
    foreach (obs_wr[i]) om[obs_wr[i][15:8]] = obs_wr[i][7:0];
    for (int a = 0; a < 256; a++) if (touched[a]) chk($sformatf("mem%0h", a), om[a], em[a]);
  endtask
  initial begin
    new_test();
    do_reset();
    dq = '{8'hF0, 8'h01};
    add_seg(8'h00, 1'b1);
    run_stream(4);
    new_test();
    do_reset();
    dq = '{8'hAA, 8'h55};
    add_seg(8'h06, 1'b0);
    dq = '{8'h11, 8'h22};
    add_seg(8'hFF, 1'b1);
    run_stream($urandom_range(0, 6));
    new_test();
    do_reset();
    add_seg(8'h05, 1'b1);
    run_stream(10);
    for (int r = 0; r < 6; r++) begin
      int nseg = $urandom_range(1, 3);
      new_test();
      do_reset();
      for (int g = 0; g < nseg; g++) begin
        int n = $urandom_range(0, 5);
        for (int i = 0; i < n; i++) dq.push_back(8'($urandom));
        add_seg(8'($urandom), g == nseg - 1);
      end
      run_stream($urandom_range(0, 12));
    end
    new_test();
    do_reset();
    send(9'h010, 0);
    send(9'h003, 0);
    send(9'h0A5, 0);
    do_reset();
    dq = '{8'h3C, 8'h7E, 8'h81};
    add_seg(8'h10, 1'b1);
    run_stream(2);
    new_test();
    do_reset();
    add_seg(8'h00, 1'b1);
    send_all();
`ifdef LOADER_TIMEOUT_EN
    repeat (T) @(posedge clk);
    #1 chk("timeout_flags", {finished, timed_out, cpu_reset}, {1'b1, 1'b1, 1'b1});
    chk("timeout_cycles", cycles, T - 1);
`else
    repeat (65540) @(posedge clk);
    #1 chk("sat_cycles", cycles, 16'hFFFF);
    chk("sat_flags", {busy, finished, timed_out, cpu_reset}, {1'b1, 1'b0, 1'b0, 1'b0});
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
